ic1406_stim_gen: RTL and testbench

- Upstream stimulus stage for the ic1406 sequential chip; drives its A0/A1/A2 inputs.
- Plays three 8-vector sweeps back to back in this order: incrementing, decrementing, scrambled.
- Exposes phase and index so a downstream checker can look up the expected {Z,Q1,Q0}.
- Vectors are registered and change only on clk posedge; each is held for a programmable number of cycles.

---
 rtl/ic1406_pkg.sv | 39 +++
 rtl/ic1406_hold_ctr.sv | 35 +++
 rtl/ic1406_stim_gen.sv | 144 ++++++++++++++
 tb/tb_ic1406_stim_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ic1406_pkg.sv
// ic1406_pkg: shared definitions for the ic1406 stimulus generator.
//   - phase encodings reported on the phase output
//   - FSM state enum
//   - scrambled-sweep vector table and a vector lookup helper
package ic1406_pkg;

    localparam int NUM_VECTORS = 8;

    localparam logic [1:0] PH_INC  = 2'd0;
    localparam logic [1:0] PH_DEC  = 2'd1;
    localparam logic [1:0] PH_SCR  = 2'd2;
    localparam logic [1:0] PH_NONE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INC,
        ST_DEC,
        ST_SCR,
        ST_DONE
    } stimState_t;

    localparam logic [2:0] SCR_TABLE [NUM_VECTORS] = '{
        3'b010, 3'b100, 3'b110, 3'b001, 3'b000, 3'b011, 3'b111, 3'b101
    };

    // Vector presented on A2..A0 for a given phase and index.
    function automatic logic [2:0] vecPattern(input logic [1:0] ph, input logic [2:0] i);
        logic [2:0] v;
        v = 3'b000;
        case (ph)
            PH_INC:  v = i;
            PH_DEC:  v = 3'd7 - i;
            PH_SCR:  v = SCR_TABLE[i];
            default: v = 3'b000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ic1406_hold_ctr.sv
// ic1406_hold_ctr: per-vector hold counter.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   clr         - synchronous clear (has priority over en)
//   en          - count enable
//   termCount   - terminal count value (HOLD_CYCLES-1)
//   tc          - high while the count equals termCount
module ic1406_hold_ctr
    import ic1406_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] termCount,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == termCount);

endmodule

// File: rtl/ic1406_stim_gen.sv
// ic1406_stim_gen: plays INC, DEC and SCR 8-vector sweeps onto the ic1406
// A2..A0 inputs, each vector held HOLD_CYCLES clocks. All outputs registered.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   start       - begins a run from IDLE or DONE (ignored mid-run)
//   abort       - returns to IDLE, priority over start
//   A0..A2      - stimulus vector (A2 = MSB)
//   vec_valid   - A2..A0 carry a sweep vector
//   phase, idx  - current sweep and position, phase = 3 when not sweeping
//   done        - run complete (level), or one-cycle pass marker in loop mode
// Build option: define IC1406_STIM_GEN_LOOP_EN to repeat the sweeps forever.
//
// state   | meaning
// IDLE    | waiting for start, outputs at reset values
// INC     | incrementing sweep, A = idx
// DEC     | decrementing sweep, A = 7 - idx
// SCR     | scrambled sweep, A = SCR_TABLE[idx]
// DONE    | run finished, done held high until start/abort
module ic1406_stim_gen
    import ic1406_pkg::*;
#(
    parameter int HOLD_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       A0,
    output logic       A1,
    output logic       A2,
    output logic       vec_valid,
    output logic [1:0] phase,
    output logic [2:0] idx,
    output logic       done
);

    stimState_t state, nextState;
    logic [2:0] aReg, nA, nIdx;
    logic [1:0] nPhase;
    logic       nValid, nDone;
    logic       running, holdTc;

    assign running = (state == ST_INC) || (state == ST_DEC) || (state == ST_SCR);

    ic1406_hold_ctr #(.CNT_W(CNT_W)) uHoldCtr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (!running || holdTc || abort),
        .en        (running),
        .termCount (CNT_W'(HOLD_CYCLES - 1)),
        .tc        (holdTc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            aReg      <= 3'b000;
            vec_valid <= 1'b0;
            phase     <= PH_NONE;
            idx       <= 3'd0;
            done      <= 1'b0;
        end else begin
            state     <= nextState;
            aReg      <= nA;
            vec_valid <= nValid;
            phase     <= nPhase;
            idx       <= nIdx;
            done      <= nDone;
        end
    end

    always_comb begin
        nextState = state;
        nA        = aReg;
        nValid    = vec_valid;
        nPhase    = phase;
        nIdx      = idx;
        nDone     = done;

        if (abort) begin
            nextState = ST_IDLE;
            nA        = 3'b000;
            nValid    = 1'b0;
            nPhase    = PH_NONE;
            nIdx      = 3'd0;
            nDone     = 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        nextState = ST_INC;
                        nA        = 3'b000;
                        nValid    = 1'b1;
                        nPhase    = PH_INC;
                        nIdx      = 3'd0;
                        nDone     = 1'b0;
                    end
                end
                ST_INC, ST_DEC, ST_SCR: begin
                    nDone = 1'b0;
                    if (holdTc) begin
                        if (idx != 3'd7) begin
                            nIdx = idx + 3'd1;
                            nA   = vecPattern(phase, nIdx);
                        end else begin
                            nIdx = 3'd0;
                            case (state)
                                ST_INC: begin
                                    nextState = ST_DEC;
                                    nPhase    = PH_DEC;
                                end
                                ST_DEC: begin
                                    nextState = ST_SCR;
                                    nPhase    = PH_SCR;
                                end
                                default: begin
`ifdef IC1406_STIM_GEN_LOOP_EN
                                    nextState = ST_INC;
                                    nPhase    = PH_INC;
                                    nDone     = 1'b1;
`else
                                    nextState = ST_DONE;
                                    nPhase    = PH_NONE;
                                    nValid    = 1'b0;
                                    nDone     = 1'b1;
`endif
                                end
                            endcase
                            // DONE uses PH_NONE, which maps to 000.
                            nA = vecPattern(nPhase, 3'd0);
                        end
                    end
                end
                default: nextState = ST_IDLE;
            endcase
        end
    end

    assign A0 = aReg[0];
    assign A1 = aReg[1];
    assign A2 = aReg[2];

endmodule

// File: tb/tb_ic1406_stim_gen.sv
// Scoreboard bench for ic1406_stim_gen: two instances (HOLD_CYCLES = 1 and 3).
// Expected vectors are queued as stimulus is issued; monitors pop and compare
// on every negedge where vec_valid is high.
module tb_ic1406_stim_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic abort = 1'b0;
    logic start1 = 1'b0, start3 = 1'b0;

    logic a0_1, a1_1, a2_1, vv1, done1;
    logic [1:0] ph1;
    logic [2:0] ix1;
    logic a0_3, a1_3, a2_3, vv3, done3;
    logic [1:0] ph3;
    logic [2:0] ix3;

    int tests = 0;
    int fails = 0;

    logic [7:0] q1[$];
    logic [7:0] q3[$];

    // Hand-written sweep: INC 0..7, DEC 7..0, SCR table
    localparam logic [2:0] EXP_A [24] = '{
        3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
        3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0,
        3'b010, 3'b100, 3'b110, 3'b001, 3'b000, 3'b011, 3'b111, 3'b101
    };

    always #5 clk = ~clk;

    ic1406_stim_gen #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
        .A0(a0_1), .A1(a1_1), .A2(a2_1), .vec_valid(vv1),
        .phase(ph1), .idx(ix1), .done(done1)
    );

    ic1406_stim_gen #(.HOLD_CYCLES(3), .CNT_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort),
        .A0(a0_3), .A1(a1_3), .A2(a2_3), .vec_valid(vv3),
        .phase(ph3), .idx(ix3), .done(done3)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Queue vector k of the 24-step sweep, reps times.
    task automatic pushVec(input int which, input int k, input int reps);
        logic [7:0] e;
        e = {EXP_A[k], 2'(k / 8), 3'(k % 8)};
        for (int r = 0; r < reps; r++) begin
            if (which == 1) q1.push_back(e);
            else            q3.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && vv1) begin
            if (q1.size() == 0) check("vec1_unexpected", {a2_1, a1_1, a0_1, ph1, ix1}, 0);
            else check("vec1", {a2_1, a1_1, a0_1, ph1, ix1}, q1.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && vv3) begin
            if (q3.size() == 0) check("vec3_unexpected", {a2_3, a1_3, a0_3, ph3, ix3}, 0);
            else check("vec3", {a2_3, a1_3, a0_3, ph3, ix3}, q3.pop_front());
        end
    end

    task automatic pulseStart(input int which);
        @(posedge clk); #1;
        if (which == 1) start1 = 1'b1; else start3 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    // Edges from the start edge until done is seen; bounded.
    task automatic waitDone(input int which, output int n);
        n = 0;
        while (n < 400 && !((which == 1) ? done1 : done3)) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic checkIdle1(input string name);
        check({name, "_A"}, {a2_1, a1_1, a0_1}, 0);
        check({name, "_vv"}, vv1, 0);
        check({name, "_ph"}, ph1, 3);
        check({name, "_idx"}, ix1, 0);
        check({name, "_done"}, done1, 0);
    endtask

    initial begin
        int n;
        int doneCnt, doneAt, drops;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        checkIdle1("rst1");
        check("rst3_vv", vv3, 0);
        check("rst3_ph", ph3, 3);
        check("rst3_done", done3, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkIdle1("postrst1");

`ifndef IC1406_STIM_GEN_LOOP_EN
        // Full run, HOLD_CYCLES = 1
        for (int k = 0; k < 24; k++) pushVec(1, k, 1);
        pulseStart(1);
        waitDone(1, n);
        check("run1_latency", n, 24);
        check("run1_vv_at_done", vv1, 0);
        check("run1_ph_at_done", ph1, 3);
        check("run1_A_at_done", {a2_1, a1_1, a0_1}, 0);
        check("run1_q_empty", q1.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("run1_done_held", done1, 1);

        // Full run, HOLD_CYCLES = 3
        for (int k = 0; k < 24; k++) pushVec(3, k, 3);
        pulseStart(3);
        waitDone(3, n);
        check("run3_latency", n, 72);
        check("run3_vv_at_done", vv3, 0);
        check("run3_q_empty", q3.size(), 0);
`else
        // Loop mode: two full passes, done pulses once at the wrap
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 24; k++) pushVec(1, k, 1);
        pulseStart(1);
        doneCnt = 0; doneAt = -1; drops = 0;
        for (int c = 1; c < 48; c++) begin
            @(posedge clk); #1;
            if (done1) begin doneCnt++; doneAt = c; end
            if (!vv1) drops++;
        end
        check("loop_done_count", doneCnt, 1);
        check("loop_done_at", doneAt, 24);
        check("loop_vv_drops", drops, 0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("loop_q_empty", q1.size(), 0);
        checkIdle1("loop_abort");
`endif

        // Abort at DEC idx 4 on dut1
        for (int k = 0; k < 13; k++) pushVec(1, k, 1);
        pulseStart(1);
        repeat (12) @(posedge clk);
        #1;
        check("abort_pre_ph", ph1, 1);
        check("abort_pre_idx", ix1, 4);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkIdle1("abort");
        check("abort_q_empty", q1.size(), 0);

        // start + abort together from IDLE: stays IDLE
        @(posedge clk); #1;
        start1 = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; abort = 1'b0;
        checkIdle1("startabort");

        // Restart after abort begins at INC idx 0
        for (int k = 0; k < 8; k++) pushVec(1, k, 1);
        pulseStart(1);
        repeat (7) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("restart_q_empty", q1.size(), 0);

        // dut3: start mid-run ignored, then async reset mid-SCR
        for (int k = 0; k < 18; k++) pushVec(3, k, 3);
        pushVec(3, 18, 1);
        pulseStart(3);
        repeat (5) @(posedge clk);
        #1;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        check("midscr_ph", ph3, 2);
        check("midscr_idx", ix3, 2);
        #1;
        rst_n = 1'b0;
        #1;
        check("asyncrst_vv", vv3, 0);
        check("asyncrst_A", {a2_3, a1_3, a0_3}, 0);
        check("asyncrst_ph", ph3, 3);
        check("asyncrst_idx", ix3, 0);
        check("asyncrst_q_empty", q3.size(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("noresume_vv", vv3, 0);
        check("noresume_ph", ph3, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
